// File: rtl/ps2_kbd_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states,
// scan-code constants for the register decode, and the frame parity check.
package ps2_kbd_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // PS/2 uses odd parity: data bits plus the parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_kbd_rx_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always on dout_o (zero when
// empty), and a push and a pop in the same cycle both take effect, even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB separates the full case from the empty case.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receive stage: synchronizes the pins, deframes 11-bit frames on
// PS/2 clock falling edges, and queues good scan codes for the bus side.
module ps2_kbd_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          parity_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]  clk_sync_q;
  logic [1:0]  dat_sync_q;
  logic        clk_prev_q;
  logic        fe;
  logic        bit_in;

  ps2_state_e  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        par_q, par_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic        push;
  logic        perr_set;
  logic        ovf_set;
  logic        overflow_q, overflow_d;
  logic        parity_err_q, parity_err_d;
  logic        fifo_full;
  logic        fifo_empty;

  // Synchronizers idle high so leaving reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign fe     = clk_prev_q & ~clk_sync_q[1];
  assign bit_in = dat_sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bitcnt_q     <= '0;
      par_q        <= 1'b0;
      timeout_q    <= '0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      par_q        <= par_d;
      timeout_q    <= timeout_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    par_d     = par_q;
    timeout_d = '0;
    push      = 1'b0;
    perr_set  = 1'b0;
    if (state_q != ST_IDLE) timeout_d = timeout_q + 1'b1;
    if (fe) begin
      timeout_d = '0;
      case (state_q)
        ST_IDLE: begin
          // A high start bit is line noise, not a frame; ignore it silently.
          if (!bit_in) begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d  = {bit_in, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = bit_in;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (bit_in && odd_parity_ok(shift_q, par_q)) push = 1'b1;
          else perr_set = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && timeout_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d   = ST_IDLE;
      timeout_d = '0;
    end
  end

  // A pop in the same cycle frees the slot, so only a push with no pop drops.
  assign ovf_set      = push & fifo_full & ~rd_en;
  assign overflow_d   = ovf_set  | (overflow_q   & ~clr_err);
  assign parity_err_d = perr_set | (parity_err_q & ~clr_err);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (shift_q),
    .pop_i   (rd_en),
    .dout_o  (rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign valid      = ~fifo_empty;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;

endmodule
